// File: rtl/fp_normalize_seq.sv
// fp_normalize_seq
//   Sequential post-addition normalizer for a floating-point adder.
//   It takes the raw adder significand (with carry-out as its MSB), the larger
//   aligned exponent and the result sign. It then normalizes the result with at
//   most one shift per clock edge and presents a packed result with flags.
//   Results are truncated; no rounding is applied.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (only while idle)
//   sum_man    raw adder significand, MSB is carry-out   [MAN_WIDTH:0]
//   exp_in     larger aligned exponent                   [EXP_WIDTH-1:0]
//   sign_in    result sign
//   out_valid  normalized result valid (held until out_ready)
//   out_ready  downstream accepts result
//   man_out    fraction field, hidden bit dropped        [MAN_WIDTH-2:0]
//   exp_out    adjusted exponent                         [EXP_WIDTH-1:0]
//   sign_out   result sign
//   zero       result is an exact zero
//   overflow   carry pushed the exponent to all-ones (fraction forced to 0)
//   underflow  result became denormal while normalizing
module fp_normalize_seq #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAN_WIDTH:0]   sum_man,
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic                 sign_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN_WIDTH-2:0] man_out,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic                 sign_out,
    output logic                 zero,
    output logic                 overflow,
    output logic                 underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [EXP_WIDTH-1:0] EXP_ONES = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0] EXP_ZERO = {EXP_WIDTH{1'b0}};
    localparam logic [EXP_WIDTH-1:0] EXP_ONE  = {{(EXP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MAN_WIDTH:0]   MAN_ZERO = {(MAN_WIDTH+1){1'b0}};
    localparam logic [MAN_WIDTH-2:0] FRAC_ZERO = {(MAN_WIDTH-1){1'b0}};

    // Control and working registers
    state_t                 state_r;
    logic                   in_ready_r;
    logic [MAN_WIDTH:0]     man_r;
    logic [EXP_WIDTH-1:0]   exp_r;
    logic                   sign_r;

    // Result registers
    logic                   out_valid_r;
    logic [MAN_WIDTH-2:0]   frac_out_r;
    logic [EXP_WIDTH-1:0]   exp_out_r;
    logic                   sign_out_r;
    logic                   zero_r;
    logic                   overflow_r;
    logic                   underflow_r;

    // Next-state values
    state_t                 state_next_s;
    logic                   in_ready_next_s;
    logic [MAN_WIDTH:0]     man_next_s;
    logic [EXP_WIDTH-1:0]   exp_next_s;
    logic                   sign_next_s;
    logic                   out_valid_next_s;
    logic [MAN_WIDTH-2:0]   frac_out_next_s;
    logic [EXP_WIDTH-1:0]   exp_out_next_s;
    logic                   sign_out_next_s;
    logic                   zero_next_s;
    logic                   overflow_next_s;
    logic                   underflow_next_s;

    // Candidate result of the current normalization step
    logic                   done_s;
    logic [MAN_WIDTH-2:0]   res_frac_s;
    logic [EXP_WIDTH-1:0]   res_exp_s;
    logic                   res_sign_s;
    logic                   res_zero_s;
    logic                   res_overflow_s;
    logic                   res_underflow_s;

    // Next-state, single normalization step and result capture
    always_comb begin
        state_next_s     = state_r;
        man_next_s       = man_r;
        exp_next_s       = exp_r;
        sign_next_s      = sign_r;
        out_valid_next_s = out_valid_r;
        frac_out_next_s  = frac_out_r;
        exp_out_next_s   = exp_out_r;
        sign_out_next_s  = sign_out_r;
        zero_next_s      = zero_r;
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;

        done_s           = 1'b0;
        res_frac_s       = man_r[MAN_WIDTH-2:0];
        res_exp_s        = exp_r;
        res_sign_s       = sign_r;
        res_zero_s       = 1'b0;
        res_overflow_s   = 1'b0;
        res_underflow_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    man_next_s   = sum_man;
                    exp_next_s   = exp_in;
                    sign_next_s  = sign_in;
                    state_next_s = NORM;
                end else begin
                    state_next_s = IDLE;
                end
            end

            NORM: begin
                // The exponent only decreases while staying in NORM, so an
                // all-ones exponent here can only be the one captured at accept.
                if (exp_r == EXP_ONES) begin
                    done_s = 1'b1;
                end else if (man_r[MAN_WIDTH]) begin
                    // Carry-out: shift right once, the shifted-out LSB is lost.
                    done_s     = 1'b1;
                    res_exp_s  = exp_r + EXP_ONE;
                    res_frac_s = man_r[MAN_WIDTH-1:1];
                    if (res_exp_s == EXP_ONES) begin
                        res_frac_s     = FRAC_ZERO;
                        res_overflow_s = 1'b1;
                    end else begin
                        res_overflow_s = 1'b0;
                    end
                end else if (man_r == MAN_ZERO) begin
                    done_s     = 1'b1;
                    res_exp_s  = EXP_ZERO;
                    res_sign_s = 1'b0;
                    res_zero_s = 1'b1;
                end else if (man_r[MAN_WIDTH-1]) begin
                    done_s = 1'b1;
                end else if (exp_r == EXP_ZERO) begin
                    // Denormal operand stays denormal.
                    done_s = 1'b1;
                end else if (exp_r == EXP_ONE) begin
                    // Cannot shift further without going below the minimum
                    // normal exponent: the result becomes denormal.
                    done_s          = 1'b1;
                    res_exp_s       = EXP_ZERO;
                    res_underflow_s = 1'b1;
                end else begin
                    done_s     = 1'b0;
                    man_next_s = {man_r[MAN_WIDTH-1:0], 1'b0};
                    exp_next_s = exp_r - EXP_ONE;
                end

                if (done_s) begin
                    state_next_s     = DONE;
                    out_valid_next_s = 1'b1;
                    frac_out_next_s  = res_frac_s;
                    exp_out_next_s   = res_exp_s;
                    sign_out_next_s  = res_sign_s;
                    zero_next_s      = res_zero_s;
                    overflow_next_s  = res_overflow_s;
                    underflow_next_s = res_underflow_s;
                end else begin
                    state_next_s = NORM;
                end
            end

            DONE: begin
                // No bypass: the handshake edge only returns to IDLE.
                if (out_ready) begin
                    state_next_s     = IDLE;
                    out_valid_next_s = 1'b0;
                end else begin
                    state_next_s = DONE;
                end
            end

            default: begin
                state_next_s     = IDLE;
                out_valid_next_s = 1'b0;
            end
        endcase

        in_ready_next_s = (state_next_s == IDLE);
    end

    // State, working and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            man_r       <= MAN_ZERO;
            exp_r       <= EXP_ZERO;
            sign_r      <= 1'b0;
            out_valid_r <= 1'b0;
            frac_out_r  <= FRAC_ZERO;
            exp_out_r   <= EXP_ZERO;
            sign_out_r  <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= in_ready_next_s;
            man_r       <= man_next_s;
            exp_r       <= exp_next_s;
            sign_r      <= sign_next_s;
            out_valid_r <= out_valid_next_s;
            frac_out_r  <= frac_out_next_s;
            exp_out_r   <= exp_out_next_s;
            sign_out_r  <= sign_out_next_s;
            zero_r      <= zero_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign man_out   = frac_out_r;
    assign exp_out   = exp_out_r;
    assign sign_out  = sign_out_r;
    assign zero      = zero_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Self-checking bench for fp_normalize_seq: randomized beats with random
// downstream backpressure, compared every cycle against a behavioural model
// that computes the result and latency directly from the normalization rules.
module tb_fp_normalize_seq;

    localparam int EW = 8;
    localparam int MW = 24;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [MW:0]   sum_man;
    logic [EW-1:0] exp_in;
    logic          sign_in;
    logic          out_valid;
    logic          out_ready;
    logic [MW-2:0] man_out;
    logic [EW-1:0] exp_out;
    logic          sign_out;
    logic          zero;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [MW-2:0] man;
        logic [EW-1:0] e;
        logic          s;
        logic          z;
        logic          o;
        logic          u;
        logic [7:0]    k;   // number of left shifts
    } res_t;

    fp_normalize_seq #(.EXP_WIDTH(EW), .MAN_WIDTH(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_man   (sum_man),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .man_out   (man_out),
        .exp_out   (exp_out),
        .sign_out  (sign_out),
        .zero      (zero),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Result of normalizing one beat, computed from the leading-one position.
    function automatic res_t model(input logic [MW:0] sm, input logic [EW-1:0] e, input logic s);
        res_t r;
        int   p;
        int   lz;
        r.man = sm[MW-2:0]; r.e = e; r.s = s;
        r.z = 1'b0; r.o = 1'b0; r.u = 1'b0; r.k = 8'd0;
        if (e == 8'd255) begin
            r.k = 8'd0;
        end else if (sm[MW]) begin
            r.e   = e + 8'd1;
            r.man = sm[MW-1:1];
            if (r.e == 8'd255) begin
                r.man = '0;
                r.o   = 1'b1;
            end
        end else if (sm == '0) begin
            r.e = 8'd0; r.s = 1'b0; r.z = 1'b1;
        end else begin
            p = 0;
            for (int i = 0; i < MW; i++) if (sm[i]) p = i;
            lz = (MW - 1) - p;
            if (lz == 0 || e == 8'd0) begin
                r.k = 8'd0;
            end else if (int'(e) > lz) begin
                r.k   = 8'(lz);
                r.e   = e - 8'(lz);
                r.man = sm[MW-2:0] << lz;
            end else begin
                r.k   = e - 8'd1;
                r.man = sm[MW-2:0] << (int'(e) - 1);
                r.e   = 8'd0;
                r.u   = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic pin(input string name, input res_t got, input res_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL model_%s: got %h expected %h", name, got, want);
        end
    endtask

    // Model state owned by the compare process
    bit   busy = 1'b0;
    res_t cur;
    int   acc_cyc;

    // Compare process: every cycle, ready/valid and (when valid) the result.
    initial begin
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checks++;
                if ({in_ready, out_valid, man_out, exp_out, sign_out, zero, overflow, underflow} !==
                    {1'b1, 1'b0, 23'd0, 8'd0, 4'b0000}) begin
                    errors++;
                    $display("FAIL reset_values: rdy=%0b vld=%0b man=%h exp=%0d s=%0b z=%0b o=%0b u=%0b expected rdy=1 rest 0",
                             in_ready, out_valid, man_out, exp_out, sign_out, zero, overflow, underflow);
                end
                busy = 1'b0;
            end else begin
                exp_valid = busy && (cyc >= acc_cyc + 1 + int'(cur.k));
                checks++;
                if (in_ready !== !busy) begin
                    errors++;
                    $display("FAIL in_ready: got %0b expected %0b at cycle %0d", in_ready, !busy, cyc);
                end
                checks++;
                if (out_valid !== exp_valid) begin
                    errors++;
                    $display("FAIL out_valid: got %0b expected %0b at cycle %0d", out_valid, exp_valid, cyc);
                end
                if (exp_valid && out_valid) begin
                    checks++;
                    if ({man_out, exp_out, sign_out, zero, overflow, underflow} !==
                        {cur.man, cur.e, cur.s, cur.z, cur.o, cur.u}) begin
                        errors++;
                        $display("FAIL result: got man=%h exp=%0d s=%0b zou=%0b%0b%0b expected man=%h exp=%0d s=%0b zou=%0b%0b%0b",
                                 man_out, exp_out, sign_out, zero, overflow, underflow,
                                 cur.man, cur.e, cur.s, cur.z, cur.o, cur.u);
                    end
                end
                if (!busy && in_valid) begin
                    cur     = model(sum_man, exp_in, sign_in);
                    busy    = 1'b1;
                    acc_cyc = cyc + 1;
                end else if (exp_valid && out_ready) begin
                    busy = 1'b0;
                end
            end
        end
    end

    // Downstream ready: random unless a test pins it.
    bit force_or = 1'b1;
    bit or_val   = 1'b1;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_or ? or_val : ($urandom_range(0, 99) < 70);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a beat until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [MW:0] sm, input logic [EW-1:0] e, input logic s);
        int n = 0;
        bit acc = 1'b0;
        sum_man = sm; exp_in = e; sign_in = s; in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            idle(1);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL drain_timeout: got busy=1 expected 0 after 500 cycles");
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0]   w;
        logic [MW:0]   sm;
        logic [EW-1:0] e;
        int            n;

        rst_n = 1'b0; in_valid = 1'b0; sum_man = '0; exp_in = '0; sign_in = 1'b0;

        // Hand-computed expectations pin the model.
        pin("carry",    model(25'h1800000, 8'd127, 1'b1), {23'h400000, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        pin("lshift",   model(25'h0100000, 8'd127, 1'b0), {23'h000000, 8'd124, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3});
        pin("zero",     model(25'h0000000, 8'd100, 1'b1), {23'h000000, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        pin("overflow", model(25'h1000000, 8'd254, 1'b0), {23'h000000, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        pin("underflw", model(25'h0100000, 8'd2,   1'b0), {23'h200000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        pin("infnan",   model(25'h0812345, 8'd255, 1'b1), {23'h012345, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        pin("denorm",   model(25'h0000010, 8'd0,   1'b0), {23'h000010, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

        #22;
        rst_n = 1'b1;
        idle(1);

        // Directed vectors with downstream always ready
        force_or = 1'b1; or_val = 1'b1;
        send(25'h1800000, 8'd127, 1'b1); wait_idle();
        send(25'h0100000, 8'd127, 1'b0); wait_idle();
        send(25'h0000000, 8'd100, 1'b1); wait_idle();
        send(25'h1000000, 8'd254, 1'b0); wait_idle();
        send(25'h0100000, 8'd2,   1'b0); wait_idle();
        send(25'h0812345, 8'd255, 1'b1); wait_idle();
        send(25'h0000010, 8'd0,   1'b0); wait_idle();
        send(25'h0000001, 8'd30,  1'b1); wait_idle();
        send(25'h0000001, 8'd200, 1'b0); wait_idle();

        // Backpressure: hold out_ready low in DONE and poke in_valid.
        or_val = 1'b0;
        send(25'h1800000, 8'd127, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            idle(1);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            sum_man  = 25'h0000003; exp_in = 8'd5; sign_in = 1'b0;
            idle(1);
        end
        in_valid = 1'b0;
        or_val = 1'b1;
        wait_idle();

        // Reset during a three-shift beat, then accept on the first edge after release.
        send(25'h0100000, 8'd127, 1'b1);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send(25'h0400000, 8'd50, 1'b0);
        wait_idle();

        // Randomized beats with random downstream readiness
        force_or = 1'b0;
        for (int t = 0; t < 300; t++) begin
            w  = $urandom;
            sm = w[MW:0] >> $urandom_range(0, MW + 1);
            if ($urandom_range(0, 9) == 0) sm = '0;
            case ($urandom_range(0, 5))
                0:       e = 8'($urandom_range(0, 3));
                1:       e = 8'($urandom_range(252, 255));
                2:       e = 8'($urandom_range(4, 30));
                default: e = 8'($urandom_range(0, 255));
            endcase
            send(sm, e, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end
        force_or = 1'b1; or_val = 1'b1;
        wait_idle();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_normalize_seq.md
FP_NORMALIZE_SEQ -- requirements
Module: fp_normalize_seq

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_WIDTH, default 24, significand width including hidden bit.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk, input, 1, rising-edge clock.
REQ-004 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have in_valid, input, 1, input beat valid.
REQ-006 SHALL have in_ready, output, 1, block can accept a beat.
REQ-007 SHALL have sum_man, input, MAN_WIDTH+1, raw adder significand; MSB is carry-out.
REQ-008 SHALL have exp_in, input, EXP_WIDTH, larger aligned exponent from the exponent subtractor stage.
REQ-009 SHALL have sign_in, input, 1, result sign.
REQ-010 SHALL have out_valid, output, 1, normalized result valid.
REQ-011 SHALL have out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have man_out, output, MAN_WIDTH-1, fraction field (hidden bit dropped).
REQ-013 SHALL have exp_out, output, EXP_WIDTH, adjusted exponent.
REQ-014 SHALL have sign_out, output, 1, result sign.
REQ-015 SHALL have zero, overflow, underflow, outputs, 1 each, result flags.

Function
REQ-016 SHALL implement FSM states IDLE, NORM, DONE; in_ready=1 only in IDLE.
REQ-017 SHALL accept a beat on the rising edge where in_valid && in_ready, registering sum_man, exp_in, sign_in into working registers and moving IDLE->NORM.
REQ-018 SHALL, in NORM, perform exactly one step per edge in this priority:
- exp == all-ones at accept: pass through unchanged, ->DONE (Inf/NaN).
- carry bit set: shift right 1, exp+1, ->DONE; if resulting exp == all-ones, force fraction 0, overflow=1.
- significand == 0: exp=0, sign=0, zero=1, ->DONE.
- bit MAN_WIDTH-1 set: ->DONE, no change.
- exp == 0: ->DONE unchanged (denormal in, denormal out, no flag).
- exp == 1: exp=0, underflow=1, ->DONE, significand unshifted.
- otherwise: shift left 1, exp-1, stay in NORM.
REQ-019 SHALL make outputs visible (out_valid=1) after 1+k edges following the accept edge, where k = number of left shifts; maximum latency MAN_WIDTH edges.
REQ-020 SHALL truncate; no rounding; shifted-out LSB on right shift discarded.
REQ-021 SHALL hold out_valid and all result outputs stable in DONE until out_valid && out_ready, then go DONE->IDLE on that edge, clearing out_valid.
REQ-022 SHALL NOT accept a new beat in the edge that leaves DONE (no bypass); next accept earliest one edge later.
REQ-023 SHALL keep flags mutually exclusive and meaningful only while out_valid=1.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, in_ready=1, out_valid=0, man_out=0, exp_out=0, sign_out=0, zero=0, overflow=0, underflow=0.
REQ-025 SHALL discard any beat in NORM or DONE when reset asserts mid-operation; no output produced for it after release.
REQ-026 SHALL accept a beat on the first rising edge after rst_n deasserts.

Verification (defaults EXP_WIDTH=8, MAN_WIDTH=24)
REQ-027 Carry: sum_man=25'h1800000, exp_in=127, sign_in=1 -> after 1 NORM edge exp_out=128, man_out=23'h400000, sign_out=1, flags 0.
REQ-028 Left shift: sum_man=25'h0100000, exp_in=127 -> out_valid 4 edges after accept, exp_out=124, man_out=0.
REQ-029 Zero/overflow: sum_man=0, exp_in=100, sign_in=1 -> exp_out=0, man_out=0, sign_out=0, zero=1; sum_man=25'h1000000, exp_in=254 -> exp_out=255, man_out=0, overflow=1.
REQ-030 Underflow: sum_man=25'h0100000, exp_in=2 -> after 2 NORM edges exp_out=0, man_out=23'h200000, underflow=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-032 Reset mid-NORM: assert rst_n=0 during a 3-shift beat -> all outputs at REQ-024 values immediately, no stale out_valid after release.
